// File: rtl/rot_pkg.sv
// Shared definitions for the rotation-engine completion/interrupt controller:
// FSM encoding, status bit positions and default geometry parameters.
package rot_pkg;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_BUSY = 2'd1,
    IC_DONE = 2'd2
  } ic_state_e;

  localparam int ST_BEF = 0;
  localparam int ST_AFT = 1;
  localparam int ST_TMO = 2;

  localparam int BPP_DEFAULT       = 3;
  localparam int BUS_BYTES_DEFAULT = 4;

endpackage

// File: rtl/rot_word_target.sv
// Output-image word count: ceil(h*w*bpp / bus_bytes), registered on load.
// The zero flag is combinational from the live h/w so the controller can
// finish a zero-sized job in the same cycle it accepts it.
module rot_word_target
  import rot_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = BPP_DEFAULT,
  parameter int BUS_BYTES       = BUS_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] h,
  input  logic [15:0] w,
  output logic [31:0] target,
  output logic        zero
);

  logic [33:0] bytes_rnd;
  logic [31:0] words;

  // Byte total rounded up to a whole bus beat; 34 bits covers 65535*65535*3+3.
  always_comb begin
    bytes_rnd = 34'(h) * 34'(w) * 34'(BYTES_PER_PIXEL) + 34'(BUS_BYTES - 1);
    words     = 32'(bytes_rnd / 34'(BUS_BYTES));
  end

  assign zero = (words == 32'd0);

  // Capture the target when a job is accepted.
  always_ff @(posedge clk) begin
    if (rst)       target <= '0;
    else if (load) target <= words;
  end

endmodule

// File: rtl/rot_intr_ctrl.sv
// Rotation-engine completion and interrupt controller.
// Counts DMA write beats against the expected word count, raises sticky
// before/after status and drives the masked interrupt.
// Optional idle-beat watchdog: define ROT_INTR_TIMEOUT_EN.
//
// state   | meaning
// IC_IDLE | no job since reset
// IC_BUSY | job accepted, counting write beats
// IC_DONE | job finished (all beats seen or watchdog expired)
module rot_intr_ctrl
  import rot_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = BPP_DEFAULT,
  parameter int BUS_BYTES       = BUS_BYTES_DEFAULT,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        I_IC_HCLK,
  input  logic        I_IC_RESET,
  input  logic        I_IC_START,
  input  logic [15:0] I_IC_NEW_H,
  input  logic [15:0] I_IC_NEW_W,
  input  logic        I_IC_WR_BEAT,
  input  logic        I_IC_INTR_MASK,
  input  logic        I_IC_BEF_MASK,
  input  logic        I_IC_AFT_MASK,
  input  logic [2:0]  I_IC_INTR_CLEAR,
  output logic        O_IC_INTR_DONE,
  output logic [2:0]  O_IC_STATUS,
  output logic        O_IC_BUSY,
  output logic [31:0] O_IC_BEAT_CNT
);

  ic_state_e   state_q, state_d;
  logic [31:0] beat_cnt_q, beat_cnt_d, beat_inc;
  logic [2:0]  status_q, status_set;
  logic [31:0] target;
  logic        target_zero;
  logic        load;
  logic        tmo_hit;

  rot_word_target #(
    .BYTES_PER_PIXEL (BYTES_PER_PIXEL),
    .BUS_BYTES       (BUS_BYTES)
  ) u_word_target (
    .clk    (I_IC_HCLK),
    .rst    (I_IC_RESET),
    .load   (load),
    .h      (I_IC_NEW_H),
    .w      (I_IC_NEW_W),
    .target (target),
    .zero   (target_zero)
  );

`ifdef ROT_INTR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_q;

  // Count consecutive beat-less cycles while a job is running.
  always_ff @(posedge I_IC_HCLK) begin
    if (I_IC_RESET || state_q != IC_BUSY || I_IC_WR_BEAT || I_IC_START)
      wdog_q <= '0;
    else
      wdog_q <= wdog_q + 1'b1;
  end

  assign tmo_hit = (state_q == IC_BUSY) && !I_IC_WR_BEAT && !I_IC_START &&
                   (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Next state, beat count and status-set events.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    status_set = '0;
    load       = 1'b0;
    beat_inc   = (beat_cnt_q == 32'hFFFF_FFFF) ? beat_cnt_q : beat_cnt_q + 32'd1;
    unique case (state_q)
      IC_IDLE, IC_DONE: begin
        if (I_IC_START) begin
          load               = 1'b1;
          beat_cnt_d         = '0;
          status_set[ST_BEF] = 1'b1;
          if (target_zero) begin
            state_d            = IC_DONE;
            status_set[ST_AFT] = 1'b1;
          end else begin
            state_d = IC_BUSY;
          end
        end
      end
      IC_BUSY: begin
        if (I_IC_WR_BEAT) begin
          beat_cnt_d = beat_inc;
          if (beat_inc == target) begin
            state_d            = IC_DONE;
            status_set[ST_AFT] = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = IC_DONE;
`ifdef ROT_INTR_TIMEOUT_EN
          status_set[ST_TMO] = 1'b1;
`endif
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  // State, counter and sticky status registers; a new event beats a clear.
  always_ff @(posedge I_IC_HCLK) begin
    if (I_IC_RESET) begin
      state_q    <= IC_IDLE;
      beat_cnt_q <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      status_q   <= (status_q & ~I_IC_INTR_CLEAR) | status_set;
    end
  end

  assign O_IC_STATUS    = status_q;
  assign O_IC_BUSY      = (state_q == IC_BUSY);
  assign O_IC_BEAT_CNT  = beat_cnt_q;
  assign O_IC_INTR_DONE = ~I_IC_INTR_MASK &
                          ((status_q[ST_BEF] & ~I_IC_BEF_MASK) |
                           (status_q[ST_AFT] & ~I_IC_AFT_MASK) |
                           status_q[ST_TMO]);

endmodule

// File: tb/tb_rot_intr_ctrl.sv
// Directed self-checking bench for rot_intr_ctrl.
module tb_rot_intr_ctrl;

  localparam int TB_TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] new_h, new_w;
  logic        wr_beat;
  logic        intr_mask, bef_mask, aft_mask;
  logic [2:0]  intr_clear;
  logic        intr_done;
  logic [2:0]  status;
  logic        busy;
  logic [31:0] beat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rot_intr_ctrl #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .I_IC_HCLK       (clk),
    .I_IC_RESET      (rst),
    .I_IC_START      (start),
    .I_IC_NEW_H      (new_h),
    .I_IC_NEW_W      (new_w),
    .I_IC_WR_BEAT    (wr_beat),
    .I_IC_INTR_MASK  (intr_mask),
    .I_IC_BEF_MASK   (bef_mask),
    .I_IC_AFT_MASK   (aft_mask),
    .I_IC_INTR_CLEAR (intr_clear),
    .O_IC_INTR_DONE  (intr_done),
    .O_IC_STATUS     (status),
    .O_IC_BUSY       (busy),
    .O_IC_BEAT_CNT   (beat_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_job(input logic [15:0] h, input logic [15:0] w);
    new_h = h;
    new_w = w;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beats(input int n);
    wr_beat = 1'b1;
    repeat (n) tick();
    wr_beat = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (status !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b expected 000", status); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (beat_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", beat_cnt); end
    n_checks++;
    if (intr_done !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b expected 0", intr_done); end
  endtask

  // 2x2 RGB = 12 bytes = 3 words
  task automatic test_basic();
    do_reset();
    start_job(16'd2, 16'd2);
    n_checks++;
    if (status !== 3'b001) begin n_fail++; $display("FAIL basic_start_status: got %b expected 001", status); end
    n_checks++;
    if (busy !== 1'b1 || beat_cnt !== 32'd0) begin n_fail++; $display("FAIL basic_start_busy: got busy=%b cnt=%0d expected busy=1 cnt=0", busy, beat_cnt); end
    beats(2);
    n_checks++;
    if (busy !== 1'b1 || beat_cnt !== 32'd2) begin n_fail++; $display("FAIL basic_mid: got busy=%b cnt=%0d expected busy=1 cnt=2", busy, beat_cnt); end
    beats(1);
    n_checks++;
    if (status !== 3'b011 || busy !== 1'b0 || beat_cnt !== 32'd3) begin n_fail++; $display("FAIL basic_done: got st=%b busy=%b cnt=%0d expected st=011 busy=0 cnt=3", status, busy, beat_cnt); end
    n_checks++;
    if (intr_done !== 1'b1) begin n_fail++; $display("FAIL basic_intr: got %b expected 1", intr_done); end
  endtask

  // 3x1 RGB = 9 bytes = 3 words; extra beat after DONE is ignored
  task automatic test_round_up();
    do_reset();
    start_job(16'd3, 16'd1);
    beats(2);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL roundup_not_early: got busy=%b expected 1", busy); end
    beats(1);
    n_checks++;
    if (busy !== 1'b0 || beat_cnt !== 32'd3 || status !== 3'b011) begin n_fail++; $display("FAIL roundup_done: got busy=%b cnt=%0d st=%b expected 0/3/011", busy, beat_cnt, status); end
    beats(1);
    n_checks++;
    if (beat_cnt !== 32'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL roundup_extra_beat: got cnt=%0d busy=%b expected cnt=3 busy=0", beat_cnt, busy); end
  endtask

  task automatic test_masks();
    do_reset();
    bef_mask = 1'b1;
    aft_mask = 1'b0;
    start_job(16'd1, 16'd4);
    n_checks++;
    if (intr_done !== 1'b0 || status !== 3'b001) begin n_fail++; $display("FAIL mask_bef: got intr=%b st=%b expected intr=0 st=001", intr_done, status); end
    beats(2);
    n_checks++;
    if (intr_done !== 1'b0) begin n_fail++; $display("FAIL mask_mid: got intr=%b expected 0", intr_done); end
    beats(1);
    n_checks++;
    if (intr_done !== 1'b1) begin n_fail++; $display("FAIL mask_aft_rise: got intr=%b expected 1", intr_done); end
    intr_mask = 1'b1;
    #1;
    n_checks++;
    if (intr_done !== 1'b0) begin n_fail++; $display("FAIL mask_global_on: got intr=%b expected 0", intr_done); end
    intr_mask = 1'b0;
    #1;
    n_checks++;
    if (intr_done !== 1'b1) begin n_fail++; $display("FAIL mask_global_off: got intr=%b expected 1", intr_done); end
    intr_clear = 3'b010;
    tick();
    intr_clear = 3'b000;
    n_checks++;
    if (status !== 3'b001 || intr_done !== 1'b0) begin n_fail++; $display("FAIL mask_clear_aft: got st=%b intr=%b expected st=001 intr=0", status, intr_done); end
    bef_mask = 1'b0;
    #1;
    n_checks++;
    if (intr_done !== 1'b1) begin n_fail++; $display("FAIL mask_bef_unmask: got intr=%b expected 1", intr_done); end
    intr_clear = 3'b111;
    tick();
    intr_clear = 3'b000;
    n_checks++;
    if (status !== 3'b000 || intr_done !== 1'b0) begin n_fail++; $display("FAIL mask_clear_all: got st=%b intr=%b expected 000/0", status, intr_done); end
  endtask

  task automatic test_set_clear_collision();
    do_reset();
    start_job(16'd1, 16'd4);
    beats(2);
    wr_beat    = 1'b1;
    intr_clear = 3'b011;
    tick();
    wr_beat    = 1'b0;
    intr_clear = 3'b000;
    n_checks++;
    if (status !== 3'b010 || busy !== 1'b0) begin n_fail++; $display("FAIL collision: got st=%b busy=%b expected st=010 busy=0", status, busy); end
  endtask

  // START while busy must not restart the count or re-latch 8x8 (48 words)
  task automatic test_start_while_busy();
    do_reset();
    start_job(16'd2, 16'd2);
    beats(1);
    start_job(16'd8, 16'd8);
    n_checks++;
    if (beat_cnt !== 32'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL busy_start_ignored: got cnt=%0d busy=%b expected cnt=1 busy=1", beat_cnt, busy); end
    beats(2);
    n_checks++;
    if (busy !== 1'b0 || beat_cnt !== 32'd3) begin n_fail++; $display("FAIL busy_start_target: got busy=%b cnt=%0d expected busy=0 cnt=3", busy, beat_cnt); end
  endtask

  task automatic test_zero_and_reset();
    do_reset();
    start_job(16'd0, 16'd5);
    n_checks++;
    if (status !== 3'b011 || busy !== 1'b0 || beat_cnt !== 32'd0) begin n_fail++; $display("FAIL zero_target: got st=%b busy=%b cnt=%0d expected 011/0/0", status, busy, beat_cnt); end
    start_job(16'd8, 16'd8);
    beats(5);
    n_checks++;
    if (busy !== 1'b1 || beat_cnt !== 32'd5) begin n_fail++; $display("FAIL restart_from_done: got busy=%b cnt=%0d expected 1/5", busy, beat_cnt); end
    do_reset();
    n_checks++;
    if (status !== 3'b000 || busy !== 1'b0 || beat_cnt !== 32'd0 || intr_done !== 1'b0) begin n_fail++; $display("FAIL midjob_reset: got st=%b busy=%b cnt=%0d intr=%b expected all 0", status, busy, beat_cnt, intr_done); end
    beats(2);
    n_checks++;
    if (beat_cnt !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_beats: got cnt=%0d busy=%b expected 0/0", beat_cnt, busy); end
  endtask

  // Largest dimensions must not wrap to a zero target
  task automatic test_max_dims();
    do_reset();
    start_job(16'hFFFF, 16'hFFFF);
    n_checks++;
    if (busy !== 1'b1 || status !== 3'b001) begin n_fail++; $display("FAIL max_dims: got busy=%b st=%b expected 1/001", busy, status); end
  endtask

`ifdef ROT_INTR_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bef_mask = 1'b1;
    aft_mask = 1'b1;
    start_job(16'd2, 16'd2);
    beats(2);
    repeat (TB_TMO - 1) tick();
    n_checks++;
    if (busy !== 1'b1 || status[2] !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got busy=%b st=%b expected busy=1 st[2]=0", busy, status); end
    tick();
    n_checks++;
    if (status !== 3'b101 || busy !== 1'b0 || intr_done !== 1'b1) begin n_fail++; $display("FAIL tmo_fire: got st=%b busy=%b intr=%b expected 101/0/1", status, busy, intr_done); end
    bef_mask = 1'b0;
    aft_mask = 1'b0;
  endtask
`else
  task automatic test_timeout();
    do_reset();
    start_job(16'd2, 16'd2);
    repeat (40) tick();
    n_checks++;
    if (busy !== 1'b1 || status !== 3'b001) begin n_fail++; $display("FAIL no_tmo: got busy=%b st=%b expected 1/001", busy, status); end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    new_h      = '0;
    new_w      = '0;
    wr_beat    = 1'b0;
    intr_mask  = 1'b0;
    bef_mask   = 1'b0;
    aft_mask   = 1'b0;
    intr_clear = 3'b000;
    #2;
    test_reset();
    test_basic();
    test_round_up();
    test_masks();
    test_set_clear_collision();
    test_start_while_busy();
    test_zero_and_reset();
    test_max_dims();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
